// File: rtl/fp_mul_seq_32bit_if.sv
// Handshake and operand/result bundle for the sequential binary32 multiplier.
// The master side supplies operands and accepts results; the slave side is the multiplier.
interface fp_mul_seq_32bit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fp_mul_seq_32bit.sv
// Sequential IEEE-754 binary32 multiplier: one shift-add mantissa step per cycle.
// Define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_seq_32bit #(
    parameter int MANT_W = 24,
    parameter int BIAS   = 127
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_mul_seq_32bit_if.slave  bus
);
    localparam int PROD_W = 2 * MANT_W;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} FpMulState;

    FpMulState          r_state, w_nextState;
    logic               r_sign;
    logic [7:0]         r_expA, r_expB;
    logic               r_aNan, r_bNan, r_aInf, r_bInf, r_aZero, r_bZero;
    logic [PROD_W-1:0]  r_mcand, r_acc;
    logic [MANT_W-1:0]  r_mplier;
    logic [4:0]         r_count;
    logic [31:0]        r_result;
    logic               r_outValid;

    logic signed [9:0]  w_expBase, w_expNorm, w_expFinal;
    logic [22:0]        w_frac, w_fracFinal;
    logic [31:0]        w_normResult;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (bus.in_valid) w_nextState = MUL;
            MUL:  if (r_count == 5'(MANT_W - 1)) w_nextState = NORM;
            NORM: w_nextState = DONE;
            DONE: if (r_outValid && bus.out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

`ifdef FP_MUL_ROUND_NEAREST_EN
    logic w_guard, w_sticky, w_roundUp, w_carry;
    logic [22:0] w_fracRnd;
`endif

    always_comb begin
        w_expBase = $signed({2'b00, r_expA}) + $signed({2'b00, r_expB}) - $signed(10'(BIAS));
        if (r_acc[PROD_W-1]) begin
            w_frac    = r_acc[46:24];
            w_expNorm = w_expBase + 10'sd1;
        end else begin
            w_frac    = r_acc[45:23];
            w_expNorm = w_expBase;
        end
`ifdef FP_MUL_ROUND_NEAREST_EN
        // A carry out of the fraction means it was all ones and wraps to zero.
        w_guard   = r_acc[PROD_W-1] ? r_acc[23] : r_acc[22];
        w_sticky  = r_acc[PROD_W-1] ? (|r_acc[22:0]) : (|r_acc[21:0]);
        w_roundUp = w_guard & (w_sticky | w_frac[0]);
        {w_carry, w_fracRnd} = {1'b0, w_frac} + 24'(w_roundUp);
        w_fracFinal = w_fracRnd;
        w_expFinal  = w_carry ? (w_expNorm + 10'sd1) : w_expNorm;
`else
        w_fracFinal = w_frac;
        w_expFinal  = w_expNorm;
`endif
        if (r_aNan || r_bNan || (r_aInf && r_bZero) || (r_bInf && r_aZero))
            w_normResult = 32'h7FC00000;
        else if (r_aInf || r_bInf)
            w_normResult = {r_sign, 8'hFF, 23'h0};
        else if (r_aZero || r_bZero)
            w_normResult = {r_sign, 31'h0};
        else if (w_expFinal >= 10'sd255)
            w_normResult = {r_sign, 8'hFF, 23'h0};
        else if (w_expFinal <= 10'sd0)
            w_normResult = {r_sign, 31'h0};
        else
            w_normResult = {r_sign, w_expFinal[7:0], w_fracFinal};
    end

    // out_valid is registered so it rises one cycle after DONE is entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_expA     <= '0;
            r_expB     <= '0;
            r_aNan     <= 1'b0;
            r_bNan     <= 1'b0;
            r_aInf     <= 1'b0;
            r_bInf     <= 1'b0;
            r_aZero    <= 1'b0;
            r_bZero    <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_result   <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_sign   <= bus.a[31] ^ bus.b[31];
                    r_expA   <= bus.a[30:23];
                    r_expB   <= bus.b[30:23];
                    r_aNan   <= (bus.a[30:23] == 8'hFF) && (bus.a[22:0] != 23'h0);
                    r_bNan   <= (bus.b[30:23] == 8'hFF) && (bus.b[22:0] != 23'h0);
                    r_aInf   <= (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == 23'h0);
                    r_bInf   <= (bus.b[30:23] == 8'hFF) && (bus.b[22:0] == 23'h0);
                    r_aZero  <= (bus.a[30:23] == 8'h00);
                    r_bZero  <= (bus.b[30:23] == 8'h00);
                    r_mcand  <= PROD_W'({1'b1, bus.a[22:0]});
                    r_mplier <= {1'b1, bus.b[22:0]};
                    r_acc    <= '0;
                    r_count  <= '0;
                end
                MUL: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 5'd1;
                end
                NORM: r_result <= w_normResult;
                DONE: begin
                    if (!r_outValid) r_outValid <= 1'b1;
                    else if (bus.out_ready) r_outValid <= 1'b0;
                end
                default: r_outValid <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_outValid;
    assign bus.result    = r_result;
endmodule

// File: tb/tb_fp_mul_seq_32bit.sv
// Directed-vector bench for fp_mul_seq_32bit: products, specials, latency, backpressure, reset.
module tb_fp_mul_seq_32bit;
    logic clk;
    logic rst_n;
    int   compareCount;
    int   mismatchCount;

    fp_mul_seq_32bit_if busIf ();

    fp_mul_seq_32bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Issue one operation with out_ready high; checks latency, in_ready, result and return to idle.
    task automatic applyStimulus(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                                 input logic [31:0] expected);
        int  latency;
        logic readySeen;
        @(negedge clk);
        busIf.out_ready = 1'b1;
        busIf.in_valid  = 1'b1;
        busIf.a         = opA;
        busIf.b         = opB;
        checkOutput({tag, "_inReadyBefore"}, 32'(busIf.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        busIf.in_valid = 1'b0;
        busIf.a        = 32'h3F800000;
        busIf.b        = 32'hC1200000;
        readySeen      = busIf.in_ready;
        latency        = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            latency = n;
            if (busIf.out_valid) break;
            if (busIf.in_ready) readySeen = 1'b1;
        end
        checkOutput({tag, "_latency"}, 32'(latency), 32'd26);
        checkOutput({tag, "_inReadyLow"}, 32'(readySeen), 32'd0);
        checkOutput({tag, "_result"}, busIf.result, expected);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_idleReady"}, 32'(busIf.in_ready), 32'd1);
        checkOutput({tag, "_validDropped"}, 32'(busIf.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] heldResult;
        logic        sawValid;
        compareCount    = 0;
        mismatchCount   = 0;
        rst_n           = 1'b0;
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b1;
        busIf.a         = '0;
        busIf.b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_inReady", 32'(busIf.in_ready), 32'd1);
        checkOutput("reset_outValid", 32'(busIf.out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busIf.busy), 32'd0);
        checkOutput("reset_result", busIf.result, 32'h0);
        rst_n = 1'b1;

        applyStimulus("two_x_three", 32'h40000000, 32'h40400000, 32'h40C00000);
        applyStimulus("neg_mixed", 32'hBFC00000, 32'h40200000, 32'hC0700000);
        applyStimulus("zero_x_neg", 32'h00000000, 32'hC0A00000, 32'h80000000);
        applyStimulus("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000);
        applyStimulus("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000);
        applyStimulus("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
        applyStimulus("nan_in", 32'h7FC00001, 32'h40000000, 32'h7FC00000);
        applyStimulus("inf_x_neg", 32'h7F800000, 32'hC0000000, 32'hFF800000);
        applyStimulus("carry_p47", 32'h3FC00000, 32'h3FC00000, 32'h40100000);
`ifdef FP_MUL_ROUND_NEAREST_EN
        applyStimulus("round_tie", 32'h3F800001, 32'h3FC00000, 32'h3FC00002);
`else
        applyStimulus("round_tie", 32'h3F800001, 32'h3FC00000, 32'h3FC00001);
`endif

        // Backpressure: result held while out_ready is low and new requests ignored.
        @(negedge clk);
        busIf.out_ready = 1'b0;
        busIf.in_valid  = 1'b1;
        busIf.a         = 32'hBFC00000;
        busIf.b         = 32'h40200000;
        @(posedge clk);
        @(negedge clk);
        busIf.in_valid = 1'b0;
        sawValid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (busIf.out_valid) begin
                sawValid = 1'b1;
                break;
            end
        end
        checkOutput("bp_validSeen", 32'(sawValid), 32'd1);
        heldResult = busIf.result;
        checkOutput("bp_result", heldResult, 32'hC0700000);
        busIf.in_valid = 1'b1;
        busIf.a        = 32'h40000000;
        busIf.b        = 32'h40400000;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_holdValid", 32'(busIf.out_valid), 32'd1);
            checkOutput("bp_holdResult", busIf.result, heldResult);
            checkOutput("bp_holdInReady", 32'(busIf.in_ready), 32'd0);
        end
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_releaseValid", 32'(busIf.out_valid), 32'd0);
        checkOutput("bp_releaseReady", 32'(busIf.in_ready), 32'd1);
        checkOutput("bp_releaseBusy", 32'(busIf.busy), 32'd0);

        // Reset in the middle of the multiply discards the operation.
        busIf.in_valid = 1'b1;
        busIf.a        = 32'h40000000;
        busIf.b        = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        busIf.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("midMul_busy", 32'(busIf.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midRst_outValid", 32'(busIf.out_valid), 32'd0);
        checkOutput("midRst_result", busIf.result, 32'h0);
        checkOutput("midRst_inReady", 32'(busIf.in_ready), 32'd1);
        checkOutput("midRst_busy", 32'(busIf.busy), 32'd0);
        rst_n = 1'b1;
        applyStimulus("after_reset", 32'h40000000, 32'h40400000, 32'h40C00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
